// File: rtl/sync_fifo_drain.sv
// Read-side drain controller for sync_fifo: bursts words into a 2-entry skid buffer and a valid/ready stream.
// Optional FIFO_DRAIN_PARITY_EN adds out_parity, stored per word at capture.
module sync_fifo_drain #(
  parameter int WIDTH     = 16,
  parameter int CNT_BITS  = 5,
  parameter int BURST_MIN = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                fifo_read,
  input  logic [WIDTH-1:0]    fifo_data,
  input  logic                fifo_empty,
  input  logic                fifo_full,
  input  logic [CNT_BITS-1:0] fifo_counter,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                busy,
  output logic [15:0]         words_sent
`ifdef FIFO_DRAIN_PARITY_EN
  ,
  output logic                out_parity
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [CNT_BITS-1:0] L_BURST = CNT_BITS'(BURST_MIN);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_pend;
  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  logic [15:0]      r_words;
  logic             w_pop;
  logic [1:0]       w_outst;
  logic             w_trigger;

  assign w_pop     = out_valid && out_ready;
  // pop implies occ >= 1, so this never wraps below zero
  assign w_outst   = r_occ + {1'b0, r_pend} - {1'b0, w_pop};
  assign w_trigger = !fifo_empty && ((fifo_counter >= L_BURST) || fifo_full || flush);
  assign fifo_read = (r_state == DRAIN) && !fifo_empty && (w_outst < 2'd2);

  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = r_buf0;
  assign busy       = (r_state == DRAIN);
  assign words_sent = r_words;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && (r_occ == 2'd0) && !r_pend) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_occ   <= 2'd0;
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= fifo_read;
      if (w_pop) r_words <= r_words + 16'd1;
      // buf0 is always the head; buf1 only holds the second word when occ==2
      case ({r_pend, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= fifo_data;
          else               r_buf1 <= fifo_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= fifo_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_DRAIN_PARITY_EN
  logic r_par0;
  logic r_par1;
  logic w_cap_par;

  assign w_cap_par  = ^fifo_data;
  assign out_parity = r_par0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par0 <= 1'b0;
      r_par1 <= 1'b0;
    end else begin
      case ({r_pend, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_par0 <= w_cap_par;
          else               r_par1 <= w_cap_par;
        end
        2'b01: r_par0 <= r_par1;
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_par0 <= w_cap_par;
          end else begin
            r_par0 <= r_par1;
            r_par1 <= w_cap_par;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Directed bench for sync_fifo_drain with a behavioural FIFO (one-cycle read latency) and an in-order word scoreboard.
module tb_sync_fifo_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_read;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_counter;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [15:0] words_sent;
`ifdef FIFO_DRAIN_PARITY_EN
  logic        out_parity;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_reads  = 0;
  logic [15:0] q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo_drain #(.WIDTH(16), .CNT_BITS(5), .BURST_MIN(4)) dut (
    .clk(clk), .reset(reset), .fifo_read(fifo_read), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_counter(fifo_counter),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .words_sent(words_sent)
`ifdef FIFO_DRAIN_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic upd_flags();
    fifo_empty   = (q.size() == 0);
    fifo_full    = (q.size() >= 32);
    fifo_counter = 5'(q.size());
  endtask

  task automatic push(input logic [15:0] w);
    q.push_back(w);
    exp_q.push_back(w);
    upd_flags();
  endtask

  // Samples pre-edge handshakes, advances one clock, then updates the FIFO model.
  task automatic tick();
    logic rd;
    #1;
    rd = fifo_read;
    if (!reset) begin
      check("no_underread", {31'd0, rd & fifo_empty}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
        else check("order", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
    if (!reset && rd === 1'b1 && q.size() != 0) begin
      fifo_data = q.pop_front();
      n_reads++;
    end
    upd_flags();
  endtask

  task automatic wait_idle(input string tag);
    int unsigned i;
    i = 0;
    while (i < 60 && (busy || out_valid || exp_q.size() != 0)) begin
      tick();
      i++;
    end
    check(tag, {31'd0, !busy && !out_valid && exp_q.size() == 0}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned run;
    logic [15:0] held;
    reset = 1'b1; out_ready = 1'b1; flush = 1'b0; fifo_data = 16'h0;
    upd_flags();

    // Reset
    tick(); tick();
    check("rst_read",  {31'd0, fifo_read}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {16'd0, out_data}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_words", {16'd0, words_sent}, 32'd0);
    reset = 1'b0;

    // Threshold
    push(16'h1111); tick();
    push(16'h2222); tick();
    push(16'h3333); tick(); tick(); tick();
    check("thr_below_read", {31'd0, fifo_read}, 32'd0);
    check("thr_below_busy", {31'd0, busy}, 32'd0);
    push(16'h4444);
    tick();
    check("thr_busy", {31'd0, busy}, 32'd1);
    check("thr_read", {31'd0, fifo_read}, 32'd1);
    wait_idle("thr_done");
    check("thr_words", {16'd0, words_sent}, 32'd4);

    // Back-pressure
    out_ready = 1'b0;
    n_reads = 0;
    push(16'hB001); push(16'hB002); push(16'hB003); push(16'hB004);
    for (int i = 0; i < 8; i++) tick();
    check("bp_reads", n_reads, 32'd2);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head",  {16'd0, out_data}, 32'h0000B001);
    held = out_data;
    tick(); tick();
    check("bp_stable", {16'd0, out_data}, {16'd0, held});
    out_ready = 1'b1;
    wait_idle("bp_done");
    check("bp_words", {16'd0, words_sent}, 32'd8);

    // Flush below threshold
    push(16'hA5A5); push(16'h5A5A);
    tick(); tick(); tick();
    check("fl_idle_busy", {31'd0, busy}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", {31'd0, busy}, 32'd1);
    wait_idle("fl_done");
    check("fl_words", {16'd0, words_sent}, 32'd10);

    // Streaming: 8 queued plus one pushed mid-stream
    for (int i = 0; i < 8; i++) push(16'hC000 + 16'(i));
    run = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        run++;
        if (run == 4) push(16'hC999);
      end else if (run != 0) begin
        break;
      end
      tick();
    end
    check("st_run", run, 32'd9);
    wait_idle("st_done");
    check("st_words", {16'd0, words_sent}, 32'd19);

    // Reset with two words buffered
    out_ready = 1'b0;
    push(16'hD001); push(16'hD002); push(16'hD003); push(16'hD004);
    for (int i = 0; i < 6; i++) tick();
    check("mr_valid_pre", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    q.delete(); exp_q.delete(); upd_flags();
    tick();
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_words", {16'd0, words_sent}, 32'd0);
    check("mr_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

`ifdef FIFO_DRAIN_PARITY_EN
    push(16'h0001); push(16'h0003);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("par_valid", {31'd0, out_valid}, 32'd1);
    check("par_data1", {16'd0, out_data}, 32'h1);
    check("par_odd",   {31'd0, out_parity}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("par_data3", {16'd0, out_data}, 32'h3);
    check("par_even",  {31'd0, out_parity}, 32'd0);
    wait_idle("par_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
